// File: rtl/hazard_interlock_pkg.sv
// Shared definitions for the decode-stage hazard interlock: register-address
// sizing, the scoreboard entry record, scoreboard slot indices and the
// RUN/STALL state encoding.
package hazard_interlock_pkg;

  // Default register-address width (8 architectural registers).
  localparam int REG_AW_DEF = 3;

  // Widest register address a scoreboard entry can hold. Narrower addresses
  // are zero-extended, so an equality compare over this width gives the same
  // answer as a compare over the real address width.
  localparam int REG_AW_MAX = 8;

  // Pipeline stages tracked behind decode, youngest first.
  localparam int SB_DEPTH = 3;
  localparam int IDX_EX   = 0;
  localparam int IDX_MEM  = 1;
  localparam int IDX_WB   = 2;

  // One in-flight instruction: does it write a register, which one, and is
  // its result coming from memory (so it is only ready late)?
  typedef struct packed {
    logic                  valid;
    logic                  is_load;
    logic [REG_AW_MAX-1:0] des;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  // Interlock FSM states.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/hazard_addr_cmp.sv
// One source-vs-scoreboard-entry compare. A hit needs the source to be read
// and the entry to hold a live writer, and the addresses to be identical.
module hazard_addr_cmp #(
  parameter int AW = 3
) (
  input  logic [AW-1:0] src,
  input  logic          src_used,
  input  logic [AW-1:0] ent_des,
  input  logic          ent_valid,
  output logic          hit
);

  // Qualified full-width address equality.
  assign hit = src_used & ent_valid & (src == ent_des);

endmodule

// File: rtl/hazard_interlock.sv
// Decode-stage read-after-write interlock with a 3-entry scoreboard
// (EX, MEM, WB), a RUN/STALL state register and a saturating stall counter.
// Build option HAZARD_FORWARD_EN: when defined, the datapath is assumed to
// forward ALU results, so only a load sitting in EX blocks a dependent reader
// (one bubble). When undefined, any live writer in EX, MEM or WB blocks it.
module hazard_interlock
  import hazard_interlock_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_src1_used,
  input  logic              id_src2_used,
  input  logic [REG_AW-1:0] id_des,
  input  logic              id_writes,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_bubble,
  output logic              stall_state,
  output logic [CNT_W-1:0]  stall_cnt
);

  sb_entry_t             sb [SB_DEPTH];
  sb_entry_t             ex_next;
  logic [REG_AW_MAX-1:0] src1_x;
  logic [REG_AW_MAX-1:0] src2_x;
  logic [SB_DEPTH-1:0]   hit1;
  logic [SB_DEPTH-1:0]   hit2;
  logic                  dep;
  logic                  stall;
  fsm_state_t            state;

  // Widen decode addresses to the entry width and build the entry that
  // follows the decoding instruction into EX.
  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    src1_x                 = '0;
    src1_x[REG_AW-1:0]     = id_src1;
    src2_x                 = '0;
    src2_x[REG_AW-1:0]     = id_src2;
    ex_next                = SB_EMPTY;
    ex_next.valid          = id_valid & id_writes & ~stall & ~flush;
    ex_next.is_load        = id_is_load;
    ex_next.des[REG_AW-1:0] = id_des;
  end

  // One comparator per (source, scoreboard entry) pair.
  for (genvar e = 0; e < SB_DEPTH; e++) begin : g_ent
    hazard_addr_cmp #(.AW(REG_AW_MAX)) u_cmp_src1 (
      .src       (src1_x),
      .src_used  (id_src1_used),
      .ent_des   (sb[e].des),
      .ent_valid (sb[e].valid),
      .hit       (hit1[e])
    );
    hazard_addr_cmp #(.AW(REG_AW_MAX)) u_cmp_src2 (
      .src       (src2_x),
      .src_used  (id_src2_used),
      .ent_des   (sb[e].des),
      .ent_valid (sb[e].valid),
      .hit       (hit2[e])
    );
  end

`ifdef HAZARD_FORWARD_EN
  // Only a load still in EX cannot be forwarded in time.
  assign dep = (hit1[IDX_EX] | hit2[IDX_EX]) & sb[IDX_EX].is_load;
`else
  // Without forwarding every in-flight writer must retire first.
  assign dep = |(hit1 | hit2);
`endif

  // An empty decode slot never stalls.
  assign stall = id_valid & dep;

  // Hold PC and IF/ID while stalled; bubble ID/EX on stall or redirect.
  assign pc_we       = ~stall;
  assign ifid_we     = ~stall;
  assign idex_bubble = stall | flush;
  assign stall_state = (state == ST_STALL);

  // Load-type flags of older entries only matter for some build options.
  logic sb_unused;
  assign sb_unused = ^{sb[IDX_MEM].is_load, sb[IDX_WB].is_load, sb[IDX_EX].is_load};

  // Scoreboard shift: decode -> EX -> MEM -> WB.
  // NOTE: the scoreboard is a few flops, not a RAM, so it is reset; that is what lets reset release a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SB_DEPTH; i++) sb[i] <= SB_EMPTY;
    end else begin
      // NOTE: non-blocking so each stage takes its neighbour's pre-edge value.
      sb[IDX_WB]  <= sb[IDX_MEM];
      sb[IDX_MEM] <= sb[IDX_EX];
      sb[IDX_EX]  <= ex_next;
    end
  end

  // RUN/STALL state follows the stall decision taken at each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (stall)  state <= ST_STALL;
        ST_STALL: if (!stall) state <= ST_RUN;
        default:              state <= ST_RUN;
      endcase
    end
  end

  // Count stalled cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_interlock.sv
// Self-checking bench for hazard_interlock (REG_AW=3, CNT_W=4). A reference
// model records, per clock edge, which instruction left decode; a writer that
// left at edge k is visible to decode for the next three cycles (only the
// first, and only if it is a load, when HAZARD_FORWARD_EN is defined).
module tb_hazard_interlock;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_src1;
  logic [2:0] id_src2;
  logic       id_src1_used;
  logic       id_src2_used;
  logic [2:0] id_des;
  logic       id_writes;
  logic       id_is_load;
  logic       flush;
  logic       pc_we;
  logic       ifid_we;
  logic       idex_bubble;
  logic       stall_state;
  logic [3:0] stall_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  hazard_interlock #(.REG_AW(3), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .id_des       (id_des),
    .id_writes    (id_writes),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .idex_bubble  (idex_bubble),
    .stall_state  (stall_state),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         edge_n   = 0;   // edges seen while out of reset
  int         rst_edge = 0;   // last edge number before the most recent reset
  logic       iss_v [0:1023];
  logic [2:0] iss_d [0:1023];
  logic       iss_l [0:1023];
  logic [3:0] m_cnt   = 4'd0;
  logic       m_state = 1'b0;

  function automatic logic m_stall();
    logic r;
    r = 1'b0;
    if (id_valid) begin
      for (int a = 1; a <= 3; a++) begin
        int  e;
        logic age_ok;
        e = edge_n - a + 1;
        if (e > rst_edge && iss_v[e % 1024]) begin
`ifdef HAZARD_FORWARD_EN
          age_ok = (a == 1) && iss_l[e % 1024];
`else
          age_ok = 1'b1;
`endif
          if (age_ok && ((id_src1_used && id_src1 == iss_d[e % 1024]) ||
                         (id_src2_used && id_src2 == iss_d[e % 1024])))
            r = 1'b1;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_edge <= edge_n;
      m_cnt    <= 4'd0;
      m_state  <= 1'b0;
    end else begin
      edge_n                     <= edge_n + 1;
      iss_v[(edge_n + 1) % 1024] <= id_valid && id_writes && !m_stall() && !flush;
      iss_d[(edge_n + 1) % 1024] <= id_des;
      iss_l[(edge_n + 1) % 1024] <= id_is_load;
      if (m_stall() && m_cnt != 4'hF) m_cnt <= m_cnt + 4'd1;
      m_state <= m_stall();
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    check("pc_we",       pc_we,       !m_stall());
    check("ifid_we",     ifid_we,     !m_stall());
    check("idex_bubble", idex_bubble, m_stall() || flush);
    check("stall_state", stall_state, m_state);
    check("stall_cnt",   stall_cnt,   m_cnt);
  end

  // ---------------- stimulus helpers ----------------
  // Present one decode slot for one cycle; returns just after the falling edge.
  task automatic cyc(input logic v, input logic [2:0] s1, input logic u1,
                     input logic [2:0] s2, input logic u2, input logic [2:0] d,
                     input logic w, input logic ld, input logic fl);
    @(posedge clk);
    #1;
    id_valid = v; id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
    id_des = d; id_writes = w; id_is_load = ld; flush = fl;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] d, input logic ld);
    cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, d, 1'b1, ld, 1'b0);
  endtask

  task automatic rd1(input logic [2:0] s);
    cyc(1'b1, s, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected results that differ between the two build options.
`ifdef HAZARD_FORWARD_EN
  localparam logic [3:0] EXP_PC_ALU  = 4'b1111;
  localparam logic [3:0] EXP_PC_LOAD = 4'b1110;
  localparam int         CNT_AFTER_ALU  = 0;
  localparam int         CNT_AFTER_LOAD = 1;
  localparam int         LOAD_STALL_LEN = 1;
`else
  localparam logic [3:0] EXP_PC_ALU  = 4'b1000;
  localparam logic [3:0] EXP_PC_LOAD = 4'b1000;
  localparam int         CNT_AFTER_ALU  = 3;
  localparam int         CNT_AFTER_LOAD = 6;
  localparam int         LOAD_STALL_LEN = 3;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] pc_pat;
    int         n;
    rst_n = 1'b0; id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_src1_used = 1'b0;
    id_src2_used = 1'b0; id_des = '0; id_writes = 1'b0; id_is_load = 1'b0; flush = 1'b0;

    // Reset values.
    #12;
    check("rst_pc_we",       pc_we,       1);
    check("rst_ifid_we",     ifid_we,     1);
    check("rst_stall_state", stall_state, 0);
    check("rst_stall_cnt",   stall_cnt,   0);
    check("rst_bubble",      idex_bubble, 0);
    flush = 1'b1;
    #1;
    check("rst_bubble_flush", idex_bubble, 1);
    flush = 1'b0;
    rst_n = 1'b1;

    // Reader with no earlier writers.
    rd1(3'd3);
    check("nodep_pc_we", pc_we,     1);
    check("nodep_cnt",   stall_cnt, 0);

    // ALU write r5, then a reader of r5 held in decode.
    wr(3'd5, 1'b0);
    pc_pat = EXP_PC_ALU;
    for (int k = 0; k < 4; k++) begin
      rd1(3'd5);
      check("alu_dep_pc_we",  pc_we,       pc_pat[k]);
      check("alu_dep_bubble", idex_bubble, !pc_pat[k]);
    end
    check("alu_dep_cnt", stall_cnt, CNT_AFTER_ALU);

    // Load r2, then a reader of r2 through source 2.
    wr(3'd2, 1'b1);
    pc_pat = EXP_PC_LOAD;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      check("load_dep_pc_we", pc_we, pc_pat[k]);
    end
    check("load_dep_cnt", stall_cnt, CNT_AFTER_LOAD);

    // Matching addresses on unused sources, and an empty decode slot.
    idle(3);
    wr(3'd6, 1'b1);
    cyc(1'b1, 3'd6, 1'b0, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    check("unused_src_pc_we", pc_we, 1);
    wr(3'd6, 1'b1);
    cyc(1'b0, 3'd6, 1'b1, 3'd6, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
    check("invalid_id_pc_we",  pc_we,       1);
    check("invalid_id_bubble", idex_bubble, 0);
    idle(3);
    rd1(3'd7);
    check("invalid_id_no_entry", pc_we, 1);

    // Addresses differing only in the top bit.
    wr(3'd1, 1'b1);
    rd1(3'd5);
    check("msb_differs_pc_we", pc_we, 1);

    // Stalled reader of r4 that is also flushed and would write r6.
    idle(3);
    wr(3'd4, 1'b1);
    cyc(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b1);
    check("flush_stall_bubble", idex_bubble, 1);
    check("flush_stall_pc_we",  pc_we,       0);
    rd1(3'd6);
    check("flush_no_ex_entry", pc_we, 1);

    // Flush without stall also keeps the writer out of the scoreboard.
    idle(3);
    cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b1, 1'b1);
    check("flush_only_bubble", idex_bubble, 1);
    check("flush_only_pc_we",  pc_we,       1);
    rd1(3'd7);
    check("flush_only_no_entry", pc_we, 1);

    // Reset asserted in the middle of a stall.
    idle(3);
    wr(3'd3, 1'b1);
    rd1(3'd3);
    check("pre_rst_pc_we", pc_we, 0);
    rd1(3'd3);
    check("pre_rst_stall_state", stall_state, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc_we",       pc_we,       1);
    check("mid_rst_ifid_we",     ifid_we,     1);
    check("mid_rst_stall_state", stall_state, 0);
    check("mid_rst_cnt",         stall_cnt,   0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Mixed traffic from a small register set so dependencies are frequent.
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)),
          1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
          1'($urandom_range(0, 7) == 0));
      n = 0;
      while (!pc_we && n < 4) begin
        n++;
        cyc(id_valid, id_src1, id_src1_used, id_src2, id_src2_used, id_des,
            id_writes, id_is_load, flush);
      end
      if (n >= 4) check("mixed_release_timeout", n, 0);
    end

    // Counter saturation: restart from zero and pile up well over 15 stalls.
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr(3'd3, 1'b1);
      rd1(3'd3);
      n = 0;
      while (!pc_we && n < 8) begin
        n++;
        rd1(3'd3);
      end
      check("stall_len", n, LOAD_STALL_LEN);
    end
    check("sat_cnt", stall_cnt, 15);
    wr(3'd3, 1'b1);
    rd1(3'd3);
    rd1(3'd3);
    check("sat_cnt_hold", stall_cnt, 15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/hazard_interlock.md
HAZARD_INTERLOCK -- requirements
Module: hazard_interlock

Interface
REQ-001 SHALL have parameter REG_AW, default 3, register-address width (8 registers).
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port id_valid  input  1  decode stage holds a real instruction.
REQ-006 SHALL have port id_src1 / id_src2  input  REG_AW each  decode source register addresses.
REQ-007 SHALL have port id_src1_used / id_src2_used  input  1 each  corresponding source is actually read.
REQ-008 SHALL have port id_des  input  REG_AW  decode destination register address.
REQ-009 SHALL have port id_writes  input  1  decode instruction writes id_des.
REQ-010 SHALL have port id_is_load  input  1  decode instruction is a memory load.
REQ-011 SHALL have port flush  input  1  branch redirect; kill the instruction leaving decode.
REQ-012 SHALL have port pc_we  output  1  PC write enable.
REQ-013 SHALL have port ifid_we  output  1  IF/ID pipeline register write enable.
REQ-014 SHALL have port idex_bubble  output  1  load NOP into ID/EX.
REQ-015 SHALL have port stall_state  output  1  FSM is in STALL (1) or RUN (0).
REQ-016 SHALL have port stall_cnt  output  CNT_W  total stalled cycles since reset.

Function
REQ-017 SHALL keep a 3-entry scoreboard (EX, MEM, WB), each entry {valid, des, is_load}.
REQ-018 SHALL compare a source with an entry only if the source is used and the entry is valid; match = address equality over all REG_AW bits.
REQ-019 SHALL compute stall combinationally in the same cycle: id_valid AND any qualifying match (see REQ-028).
REQ-020 SHALL drive pc_we = ifid_we = NOT stall; idex_bubble = stall OR flush.
REQ-021 SHALL, at each clock edge, shift: WB<=MEM, MEM<=EX; EX<={id_valid AND id_writes AND NOT stall AND NOT flush, id_des, id_is_load}.
REQ-022 SHALL treat flush and stall together as flush: bubble inserted, pc_we still follows NOT stall.
REQ-023 SHALL implement FSM states RUN and STALL: RUN->STALL when stall=1 at the edge; STALL->RUN when stall=0 at the edge; otherwise remain.
REQ-024 SHALL increment stall_cnt by 1 on each edge where stall=1, saturating at all-ones (no wrap).
REQ-025 SHALL deassert stall within at most 3 consecutive cycles for any single dependency, since bubbles drain the scoreboard.
REQ-026 SHALL ignore id_src*/id_des/id_writes/id_is_load when id_valid=0 (no stall, no scoreboard entry).

Reset
REQ-027 SHALL, while rst_n=0 (asynchronous), clear all scoreboard entries to invalid, FSM to RUN, stall_cnt to 0; hence pc_we=1, ifid_we=1, idex_bubble=flush, stall_state=0; reset mid-stall releases the stall immediately.

Configuration
REQ-028 SHALL support macro HAZARD_FORWARD_EN: defined -> stall only on a match with EX where EX.is_load=1 (load-use, one bubble); undefined -> stall on a match with any of EX, MEM or WB.

Structure
REQ-029 SHALL place REG_AW default, the scoreboard-entry typedef and FSM state encodings in the shared cpu package.
REQ-030 SHALL instantiate one sub-module, hazard_addr_cmp, per (source, entry) pair, performing the equality compare with used/valid qualification.

Verification
REQ-031 Reset then id_valid=1, src1=3 used, no prior writers -> stall=0, pc_we=1, stall_cnt=0.
REQ-032 Without HAZARD_FORWARD_EN: cycle 0 writes r5; cycle 1 reads r5 -> stall for 3 cycles, idex_bubble=1 each, stall_cnt=3, then pc_we=1.
REQ-033 With HAZARD_FORWARD_EN: load to r2 then immediate reader of r2 -> exactly 1 stall cycle; ALU write to r2 then reader -> 0 stalls.
REQ-034 Stalled reader of r4 plus flush=1 in same cycle -> idex_bubble=1, EX entry invalid, pc_we=0 that cycle.
REQ-035 rst_n pulled low during a stall -> pc_we=1 and stall_state=0 asynchronously, stall_cnt=0.
REQ-036 Force stall_cnt to all-ones (CNT_W=4, 15) then another stall -> stall_cnt stays 15.
